// File: rtl/serial_reader_pkg.sv
// Shared definitions for the serial_reader block.
// Holds the FSM state encoding, the default word width and a helper that
// sizes the bit counter for a given word width.
package serial_reader_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width: clog2(width) bits, never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit counter used by serial_reader to track how many bits of the current
// word have been transferred.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset (count -> 0)
//   clear  - synchronous clear (count -> 0), takes priority over inc
//   inc    - increment enable
//   count  - current count
module bit_counter #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Counter register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/serial_reader.sv
// Parallel-to-serial reader: captures a WIDTH-bit word on load and shifts it
// out LSB first over a valid/ready handshake, pulsing done for one cycle
// after the last bit is accepted.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset
//   load       - capture data_in (honoured only in IDLE)
//   data_in    - parallel word to serialize
//   out_ready  - consumer accepts serial_out this cycle
//   serial_out - current bit (0 when out_valid is low)
//   out_valid  - serial_out holds a valid bit
//   busy       - a word is being shifted out
//   done       - one-cycle pulse after the last transfer
module serial_reader
  import serial_reader_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             serial_out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic             done_next;
  logic             cnt_clear;
  logic             cnt_inc;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  bit_counter #(
    .W (CW)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (cnt)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State, shift register and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      sreg  <= sreg_next;
      done  <= done_next;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    done_next  = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          sreg_next  = data_in;
          cnt_clear  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // load is ignored here; only a handshake moves the word along.
        if (out_ready) begin
          sreg_next = sreg >> 1;
          if (last_bit) begin
            // Clear rather than increment so the count never reaches WIDTH.
            cnt_clear  = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  assign out_valid  = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign serial_out = (state == SHIFT) ? sreg[0] : 1'b0;

endmodule

// File: tb/tb_serial_reader.sv
// Self-checking bench for serial_reader: a directed vector table, directed
// multi-cycle scenarios, randomized traffic against a queue-based model, and
// a WIDTH=1 instance.
module tb_serial_reader;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] data_in;
  logic       out_ready;
  logic       serial_out;
  logic       out_valid;
  logic       busy;
  logic       done;

  logic       reset1;
  logic       load1;
  logic [0:0] data_in1;
  logic       out_ready1;
  logic       serial_out1;
  logic       out_valid1;
  logic       busy1;
  logic       done1;

  int checks;
  int failures;

  serial_reader #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .out_ready  (out_ready),
    .serial_out (serial_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  serial_reader #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .reset      (reset1),
    .load       (load1),
    .data_in    (data_in1),
    .out_ready  (out_ready1),
    .serial_out (serial_out1),
    .out_valid  (out_valid1),
    .busy       (busy1),
    .done       (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bits still owed for the current word, oldest first.
  bit mq[$];
  bit m_done;
  // Bits actually handed over on handshakes, recorded for word-level checks.
  bit got[$];

  function automatic void model_step(input logic rst, input logic ld,
                                     input logic [7:0] din, input logic rdy);
    if (rst) begin
      mq.delete();
      m_done = 1'b0;
    end else if (mq.size() != 0) begin
      m_done = 1'b0;
      if (rdy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (ld) for (int i = 0; i < 8; i++) mq.push_back(din[i]);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] got_word();
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < got.size() && i < 8; i++) w[i] = got[i];
    return w;
  endfunction

  // One clock of the 8-bit instance, checked against the model.
  task automatic cycle(input logic rst, input logic ld, input logic [7:0] din, input logic rdy);
    logic ev;
    reset = rst; load = ld; data_in = din; out_ready = rdy;
    if (!rst && out_valid && rdy) got.push_back(serial_out);
    @(posedge clk);
    model_step(rst, ld, din, rdy);
    #1;
    ev = (mq.size() != 0);
    check("serial_out", 32'(serial_out), 32'(ev ? mq[0] : 1'b0));
    check("out_valid",  32'(out_valid),  32'(ev));
    check("busy",       32'(busy),       32'(ev));
    check("done",       32'(done),       32'(m_done));
  endtask

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] din;
    logic       rdy;
    logic       e_ser;
    logic       e_val;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];
  int   done_cnt;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; load = 1'b0; data_in = '0; out_ready = 1'b0;
    reset1 = 1'b0; load1 = 1'b0; data_in1 = '0; out_ready1 = 1'b0;

    // 8'hA5 streamed with out_ready high: bits 1,0,1,0,0,1,0,1 then done.
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    foreach (vecs[k]) begin
      reset = vecs[k].rst; load = vecs[k].ld; data_in = vecs[k].din; out_ready = vecs[k].rdy;
      @(posedge clk);
      model_step(vecs[k].rst, vecs[k].ld, vecs[k].din, vecs[k].rdy);
      #1;
      check($sformatf("vec%0d serial_out", k), 32'(serial_out), 32'(vecs[k].e_ser));
      check($sformatf("vec%0d out_valid", k),  32'(out_valid),  32'(vecs[k].e_val));
      check($sformatf("vec%0d busy", k),       32'(busy),       32'(vecs[k].e_busy));
      check($sformatf("vec%0d done", k),       32'(done),       32'(vecs[k].e_done));
    end

    // 8'h3C with a 3-cycle stall after bit 2; serial_out must hold 1.
    got.delete();
    cycle(1'b0, 1'b1, 8'h3C, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check("stall hold", 32'(serial_out), 32'd1);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("3C transfers", 32'(got.size()), 32'd8);
    check("3C word", 32'(got_word()), 32'h3C);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // load of 8'hFF mid-word and on the final transfer must be ignored.
    got.delete();
    cycle(1'b0, 1'b1, 8'h0F, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'hFF, 1'b1);
    check("0F transfers", 32'(got.size()), 32'd8);
    check("0F word", 32'(got_word()), 32'h0F);
    check("0F done", 32'(done), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // load held high: 8'h81 then 8'h7E, second accepted in the done cycle.
    got.delete();
    done_cnt = 0;
    cycle(1'b0, 1'b1, 8'h81, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h7E, 1'b1);
      if (done) done_cnt++;
    end
    check("81 word", 32'(got_word()), 32'h81);
    got.delete();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, (i == 0) ? 1'b1 : 1'b0, 8'h7E, 1'b1);
      if (done) done_cnt++;
    end
    check("7E word", 32'(got_word()), 32'h7E);
    check("7E transfers", 32'(got.size()), 32'd8);
    check("done pulses", 32'(done_cnt), 32'd2);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset after bit 4 of 8'hC3 aborts the word; 8'h01 then streams cleanly.
    cycle(1'b0, 1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b1, 8'hFF, 1'b1);
    check("abort valid", 32'(out_valid), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort serial", 32'(serial_out), 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("abort no done", 32'(done), 32'd0);
    got.delete();
    cycle(1'b0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("01 word", 32'(got_word()), 32'h01);
    check("01 transfers", 32'(got.size()), 32'd8);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            1'(($urandom() >> 3) & 1),
            8'($urandom()),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // WIDTH=1 instance.
    reset1 = 1'b1; @(posedge clk); #1;
    check("w1 reset valid", 32'(out_valid1), 32'd0);
    check("w1 reset done", 32'(done1), 32'd0);
    reset1 = 1'b0; load1 = 1'b1; data_in1 = 1'b1; out_ready1 = 1'b0;
    @(posedge clk); #1;
    check("w1 valid", 32'(out_valid1), 32'd1);
    check("w1 serial", 32'(serial_out1), 32'd1);
    check("w1 busy", 32'(busy1), 32'd1);
    load1 = 1'b0;
    @(posedge clk); #1;
    check("w1 stall valid", 32'(out_valid1), 32'd1);
    check("w1 stall done", 32'(done1), 32'd0);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    check("w1 done", 32'(done1), 32'd1);
    check("w1 idle valid", 32'(out_valid1), 32'd0);
    check("w1 idle serial", 32'(serial_out1), 32'd0);
    @(posedge clk); #1;
    check("w1 done drop", 32'(done1), 32'd0);
    check("w1 busy drop", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_reader.md
SERIAL_READER -- requirements
Module: serial_reader

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits in the parallel word being read out.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: load  input  1  request to capture data_in; honoured only in IDLE.
REQ-005 Port: data_in  input  WIDTH  parallel word to serialize.
REQ-006 Port: out_ready  input  1  consumer accepts serial_out this cycle.
REQ-007 Port: serial_out  output  1  current bit, LSB first.
REQ-008 Port: out_valid  output  1  serial_out holds a valid bit.
REQ-009 Port: busy  output  1  high while a word is being shifted out.
REQ-010 Port: done  output  1  one-cycle pulse after the last bit is accepted.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-012 In IDLE with load=1 at a clk edge, the block SHALL capture data_in into an internal WIDTH-bit shift register, clear the bit counter, and enter SHIFT.
REQ-013 In IDLE with load=0, all state SHALL hold; out_valid=0, busy=0.
REQ-014 In SHIFT, out_valid and busy SHALL be 1, and serial_out SHALL equal shift register bit 0.
REQ-015 A transfer SHALL occur on a clk edge where out_valid=1 and out_ready=1; only then SHALL the register shift right by one (zero fill) and the counter increment.
REQ-016 With out_ready=0 in SHIFT, serial_out, the register, and the counter SHALL hold unchanged (stall, no bit lost or duplicated).
REQ-017 Latency: the first bit SHALL be valid the cycle after load is sampled; with out_ready held high, WIDTH bits SHALL appear on WIDTH consecutive cycles.
REQ-018 On the transfer with counter = WIDTH-1, the FSM SHALL return to IDLE and done SHALL be 1 for exactly the following cycle.
REQ-019 load asserted while in SHIFT, including the cycle of the final transfer, SHALL be ignored; data_in is not sampled.
REQ-020 load asserted in the cycle done is high SHALL be accepted (FSM is IDLE), giving back-to-back words with one idle cycle between them.
REQ-021 The counter SHALL be clog2(WIDTH) bits wide (minimum 1) and SHALL never exceed WIDTH-1.
REQ-022 serial_out SHALL be 0 whenever out_valid=0.

Reset
REQ-023 reset=1 at a clk edge SHALL force IDLE, clear the shift register and counter, and drive serial_out=0, out_valid=0, busy=0, done=0.
REQ-024 reset SHALL override load and any transfer in the same cycle; reset mid-SHIFT SHALL abort the word with no done pulse.
REQ-025 Before the first reset edge, outputs are unspecified; the bench SHALL apply reset before checking outputs.

Structure
REQ-026 The FSM state encodings (IDLE=0, SHIFT=1) and the default WIDTH SHALL live in the shared defines include file.
REQ-027 The bit counter SHALL be a sub-module, bit_counter (clear, increment enable, count output, synchronous active-high reset).
REQ-028 All state SHALL be registered on posedge clk; outputs SHALL be decoded only from registered state.

Verification
REQ-029 Reset then load=1 with data_in=8'hA5, out_ready=1 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; done pulses once; busy falls.
REQ-030 data_in=8'h3C with out_ready low for 3 cycles after bit 2 -> bits 0,0,1 are emitted, serial_out holds 1 through the stall, sequence resumes 1,1,1,0,0; total 8 transfers.
REQ-031 load=1 with data_in=8'hFF issued mid-word of 8'h0F -> output remains 8'h0F's bits; 8'hFF is never emitted.
REQ-032 load held high continuously with data_in=8'h81 then 8'h7E -> two words, 8 bits each, done pulse between them, load re-accepted in the done cycle.
REQ-033 reset asserted after bit 4 of 8'hC3 -> next cycle out_valid=0, busy=0, done=0, serial_out=0; a new load of 8'h01 then emits 1,0,0,0,0,0,0,0.
REQ-034 WIDTH=1 instance, data_in=1 -> one valid cycle with serial_out=1, then done pulse.
